dm_load_unit: RTL and testbench
===============================

Name: dm_load_unit

Overview:
- Load-side counterpart of the data-memory store path; sits in the MEM stage between the pipeline and a data memory with variable latency.
- Issues word-aligned read requests, waits on a ready handshake, and stalls the pipeline while the read is outstanding.
- Extracts byte/halfword lanes with sign or zero extension and returns the result to the writeback path.
- Keeps the last load result for store-data forwarding (optional).

Parameters:
TIMEOUT, 16, max cycles in WAIT before a bus error is declared (>=2)
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
mem_read  input  1  MEM-stage instruction is a load
addr  input  32  byte address from ALU Result
load_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101-111 reserved, treated as LW
dm_req  output  1  read request to data memory
dm_addr  output  32  word address ({addr[31:2],2'b00})
dm_rdata  input  32  memory read data, valid when dm_ready=1
dm_ready  input  1  memory read-data-valid handshake
load_data  output  32  extended load result (mem_result)
load_valid  output  1  one-cycle pulse: load_data updated this cycle
stall  output  1  freeze PC/IF/ID/EX/MEM registers
addr_err  output  1  misaligned-load exception (combinational)
bus_err  output  1  one-cycle pulse: timeout; load_data forced to 0
fwd_data  output  32  last completed load data (LOAD_FWD_EN)
fwd_valid  output  1  fwd_data holds a valid load result (LOAD_FWD_EN)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; dm_req=0, dm_addr=0, load_data=0, load_valid=0, bus_err=0, wait counter=0, fwd_data=0, fwd_valid=0. Reset overrides any in-flight read; a dm_ready arriving after reset is ignored.
- States: IDLE, WAIT, DONE.
- Alignment: misaligned = (LW or reserved, addr[1:0]!=0) or (LH/LHU, addr[0]!=0). Byte loads are never misaligned.
- IDLE: if mem_read=1 and misaligned, addr_err=1 combinationally, no request, no stall, stay IDLE. If mem_read=1 and aligned, stall=1 combinationally, latch addr/load_type, next state WAIT with dm_req=1 and dm_addr registered.
- WAIT: dm_req=1, dm_addr and latched type held stable, stall=1, and the counter increments each cycle.
  - If dm_ready=1: capture extracted dm_rdata into load_data, clear the counter, next state DONE.
  - Else if counter==TIMEOUT-1: load_data=0 and bus_err=1 in DONE, then next state DONE.
  - dm_ready takes priority over timeout in the same cycle.
- DONE: dm_req=0, stall=0, load_valid=1 (and bus_err if timed out) for exactly one cycle, next state IDLE. mem_read seen in DONE belongs to the same instruction and is ignored.
- dm_ready while dm_req=0 is ignored.
- Latency: mem_read at cycle T, dm_req high from T+1, dm_ready at T+k (k>=1), then load_valid at T+k+1. Stall is high T..T+k; minimum occupancy is 3 cycles.
- Extraction (little-endian, lane n = bits 8n+7:8n):
  - LW: word as-is.
  - LH/LHU: halfword addr[1] (0 selects bits 15:0, 1 selects bits 31:16), sign- or zero-extended.
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
- load_data holds its value between loads.
- Back-to-back loads: each takes its own IDLE→WAIT→DONE pass; no overlap and no request in the DONE cycle.

Optional Feature:
LOAD_FWD_EN
- Defined: on every successful load completion (entry to DONE with dm_ready), fwd_data is set to the extracted value and fwd_valid=1. A bus error clears fwd_valid. fwd_valid remains 1 until the next load or reset, so a following store can forward the load result.
- Undefined: fwd_data=0 and fwd_valid=0 constantly, and no forwarding register is synthesized.

Test Plan:
- Reset mid-WAIT (dm_req=1), then dm_ready=1 one cycle after reset: dm_req=0 and load_valid stays 0; load_data=0.
- LW addr=0x100, dm_ready at first WAIT cycle, dm_rdata=0xDEADBEEF: dm_addr=0x100; stall high 2 cycles; load_data=0xDEADBEEF with load_valid pulse at T+2.
- LB addr=0x103, dm_rdata=0x80123456 gives load_data=0xFFFFFF80; LBU same gives 0x00000080; LH addr=0x102 gives 0xFFFF8012; LHU addr=0x100 gives 0x00003456.
- LW addr=0x102: addr_err=1 the same cycle, dm_req stays 0, stall=0, load_data unchanged.
- No dm_ready for TIMEOUT=16 cycles: bus_err and load_valid pulse together, load_data=0, stall drops; the next load proceeds normally.
- LOAD_FWD_EN defined, LW returning 0x12345678 followed by a second LW with dm_ready delayed 5 cycles: fwd_data=0x12345678 and fwd_valid=1 throughout the second load's WAIT; both updated at the second DONE.

Source files
------------

// File: rtl/dm_load_unit.sv
// MEM-stage load unit: word-aligned read with ready handshake, pipeline stall, lane extraction.
// Optional store-data forwarding register enabled by defining LOAD_FWD_EN.
module dm_load_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [2:0]  load_type,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] fwd_data,
  output logic        fwd_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  state_t           state, next_state;
  logic [2:0]       lat_type;
  logic [1:0]       lat_lane;
  logic [CNT_W-1:0] cnt;
  logic             misaligned;
  logic             start;
  logic             timeout;
  logic [31:0]      ext_data;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    misaligned = 1'b0;
    case (load_type)
      LT_LH, LT_LHU: misaligned = addr[0];
      LT_LB, LT_LBU: misaligned = 1'b0;
      default:       misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  assign start    = (state == S_IDLE) && mem_read && !misaligned;
  assign timeout  = (cnt == CNT_W'(TIMEOUT - 1));
  assign addr_err = (state == S_IDLE) && mem_read && misaligned;
  assign stall    = start || (state == S_WAIT);
  assign dm_req   = (state == S_WAIT);

  // Little-endian lane select using the address/type latched at request time.
  always_comb begin
    logic [15:0] half;
    logic [7:0]  byte_v;
    half     = lat_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    byte_v   = dm_rdata[8*lat_lane +: 8];
    ext_data = dm_rdata;
    case (lat_type)
      LT_LH:   ext_data = {{16{half[15]}}, half};
      LT_LHU:  ext_data = {16'h0000, half};
      LT_LB:   ext_data = {{24{byte_v[7]}}, byte_v};
      LT_LBU:  ext_data = {24'h000000, byte_v};
      default: ext_data = dm_rdata;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_WAIT;
      S_WAIT:  if (dm_ready || timeout) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dm_addr    <= '0;
      lat_type   <= '0;
      lat_lane   <= '0;
      cnt        <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= next_state;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      if (start) begin
        dm_addr  <= {addr[31:2], 2'b00};
        lat_type <= load_type;
        lat_lane <= addr[1:0];
        cnt      <= '0;
      end
      if (state == S_WAIT) begin
        if (dm_ready) begin
          load_data  <= ext_data;
          load_valid <= 1'b1;
          cnt        <= '0;
        end else if (timeout) begin
          load_data  <= '0;
          load_valid <= 1'b1;
          bus_err    <= 1'b1;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef LOAD_FWD_EN
  // Holds the last good load result until the next completion, for a following store.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_data  <= '0;
      fwd_valid <= 1'b0;
    end else if (state == S_WAIT) begin
      if (dm_ready) begin
        fwd_data  <= ext_data;
        fwd_valid <= 1'b1;
      end else if (timeout) begin
        fwd_valid <= 1'b0;
      end
    end
  end
`else
  assign fwd_data  = '0;
  assign fwd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed, table-driven bench for dm_load_unit: reset, lane extraction, misalignment, timeout, forwarding.
`timescale 1ns/1ps
module tb_dm_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic [31:0] addr;
  logic [2:0]  load_type;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;
  logic        addr_err;
  logic        bus_err;
  logic [31:0] fwd_data;
  logic        fwd_valid;

`ifdef LOAD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  dm_load_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .addr(addr), .load_type(load_type),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .load_data(load_data), .load_valid(load_valid), .stall(stall), .addr_err(addr_err),
    .bus_err(bus_err), .fwd_data(fwd_data), .fwd_valid(fwd_valid)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  ltype;
    logic [31:0] rdata;
    int          delay;
    logic        mis;
    logic [31:0] exp;
  } vec_t;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] last_data = '0;
  logic [31:0] fwd_exp   = '0;
  logic        fwd_v_exp = 1'b0;
  vec_t        vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fwd(input string tag);
    check({tag, " fwd_data"},  fwd_data,  FWD_EN ? fwd_exp : 32'h0);
    check({tag, " fwd_valid"}, {31'h0, fwd_valid}, {31'h0, FWD_EN & fwd_v_exp});
  endtask

  task automatic do_load(input vec_t v);
    mem_read  = 1'b1;
    addr      = v.addr;
    load_type = v.ltype;
    #1;
    if (v.mis) begin
      check("mis addr_err", {31'h0, addr_err}, 32'h1);
      check("mis stall",    {31'h0, stall},    32'h0);
      tick();
      check("mis dm_req",    {31'h0, dm_req}, 32'h0);
      check("mis load_data", load_data, last_data);
      mem_read = 1'b0;
      return;
    end
    check("issue addr_err", {31'h0, addr_err}, 32'h0);
    check("issue stall",    {31'h0, stall},    32'h1);
    tick();
    check("wait dm_req",  {31'h0, dm_req}, 32'h1);
    check("wait dm_addr", dm_addr, {v.addr[31:2], 2'b00});
    check_fwd("wait");
    for (int i = 0; i < v.delay; i++) begin
      check("wait stall", {31'h0, stall}, 32'h1);
      tick();
    end
    check_fwd("late wait");
    dm_ready = 1'b1;
    dm_rdata = v.rdata;
    #1;
    check("ready stall", {31'h0, stall}, 32'h1);
    tick();
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
    check("done load_valid", {31'h0, load_valid}, 32'h1);
    check("done load_data",  load_data, v.exp);
    check("done bus_err",    {31'h0, bus_err}, 32'h0);
    check("done stall",      {31'h0, stall},   32'h0);
    check("done dm_req",     {31'h0, dm_req},  32'h0);
    fwd_exp   = v.exp;
    fwd_v_exp = 1'b1;
    check_fwd("done");
    last_data = v.exp;
    tick();
    mem_read = 1'b0;
    check("idle load_valid", {31'h0, load_valid}, 32'h0);
  endtask

  initial begin
    //           addr          type    rdata         dly mis expected
    vecs[0]  = '{32'h0000_0100, 3'b000, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_0103, 3'b011, 32'h8012_3456, 0, 0, 32'hFFFF_FF80};
    vecs[2]  = '{32'h0000_0103, 3'b100, 32'h8012_3456, 1, 0, 32'h0000_0080};
    vecs[3]  = '{32'h0000_0102, 3'b001, 32'h8012_3456, 0, 0, 32'hFFFF_8012};
    vecs[4]  = '{32'h0000_0100, 3'b010, 32'h8012_3456, 0, 0, 32'h0000_3456};
    vecs[5]  = '{32'h0000_0100, 3'b011, 32'h8012_3456, 0, 0, 32'h0000_0056};
    vecs[6]  = '{32'h0000_0101, 3'b100, 32'h8012_3456, 2, 0, 32'h0000_0034};
    vecs[7]  = '{32'h0000_0101, 3'b011, 32'h0000_F000, 0, 0, 32'hFFFF_FFF0};
    vecs[8]  = '{32'h0000_0100, 3'b001, 32'h1234_ABCD, 0, 0, 32'hFFFF_ABCD};
    vecs[9]  = '{32'h0000_0102, 3'b010, 32'hFFFF_0000, 0, 0, 32'h0000_FFFF};
    vecs[10] = '{32'h0000_0204, 3'b111, 32'hCAFE_F00D, 3, 0, 32'hCAFE_F00D};
    vecs[11] = '{32'h0000_0102, 3'b000, 32'h0,         0, 1, 32'h0};
    vecs[12] = '{32'h0000_0101, 3'b001, 32'h0,         0, 1, 32'h0};
    vecs[13] = '{32'h0000_0301, 3'b101, 32'h0,         0, 1, 32'h0};
    vecs[14] = '{32'h0000_0400, 3'b000, 32'h1234_5678, 0, 0, 32'h1234_5678};
    vecs[15] = '{32'h0000_0407, 3'b100, 32'h7F00_0000, 5, 0, 32'h0000_007F};

    rst = 1'b1; mem_read = 1'b0; addr = '0; load_type = '0; dm_rdata = '0; dm_ready = 1'b0;
    tick();
    tick();
    check("rst dm_req",     {31'h0, dm_req},     32'h0);
    check("rst dm_addr",    dm_addr,             32'h0);
    check("rst load_data",  load_data,           32'h0);
    check("rst load_valid", {31'h0, load_valid}, 32'h0);
    check("rst bus_err",    {31'h0, bus_err},    32'h0);
    check_fwd("rst");
    rst = 1'b0;

    // Reset during WAIT; a late dm_ready must be ignored.
    mem_read = 1'b1; addr = 32'h0000_0500; load_type = 3'b000;
    tick();
    mem_read = 1'b0;
    check("midwait dm_req", {31'h0, dm_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midwait dm_addr", dm_addr, 32'h0);
    dm_ready = 1'b1; dm_rdata = 32'h1111_1111;
    tick();
    dm_ready = 1'b0; dm_rdata = 32'h0;
    check("postrst dm_req",     {31'h0, dm_req},     32'h0);
    check("postrst load_valid", {31'h0, load_valid}, 32'h0);
    check("postrst load_data",  load_data,           32'h0);
    check("postrst stall",      {31'h0, stall},      32'h0);
    tick();
    check("postrst2 load_valid", {31'h0, load_valid}, 32'h0);

    for (int i = 0; i < 16; i++) do_load(vecs[i]);

    // Timeout: no dm_ready for 16 WAIT cycles.
    mem_read = 1'b1; addr = 32'h0000_0600; load_type = 3'b000;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("to last wait stall",  {31'h0, stall},      32'h1);
    check("to last wait dm_req", {31'h0, dm_req},     32'h1);
    check("to last wait valid",  {31'h0, load_valid}, 32'h0);
    tick();
    check("to bus_err",    {31'h0, bus_err},    32'h1);
    check("to load_valid", {31'h0, load_valid}, 32'h1);
    check("to load_data",  load_data,           32'h0);
    check("to stall",      {31'h0, stall},      32'h0);
    fwd_v_exp = 1'b0;
    check_fwd("to");
    last_data = 32'h0;
    tick();
    mem_read = 1'b0;
    check("to bus_err pulse", {31'h0, bus_err}, 32'h0);

    do_load('{32'h0000_0700, 3'b000, 32'hA5A5_5A5A, 1, 0, 32'hA5A5_5A5A});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
